// File: rtl/life_pkg.sv
// Shared types and the Game-of-Life cell rule for the life generation engine.
package life_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      SWAP    = 2'd2
   } state_t;

   localparam int NBR_W = 4;

   function automatic logic life_rule(input logic i_alive, input logic [NBR_W-1:0] i_n);
      return (i_n == NBR_W'(3)) || (i_alive && (i_n == NBR_W'(2)));
   endfunction

endpackage

// File: rtl/life_row_update.sv
// Combinational next-state for one board row from its row above, itself and the row below.
// Column edges wrap when LIFE_TORUS_EN is defined, otherwise off-board columns read as dead.
module life_row_update
   import life_pkg::*;
#(
   parameter int BOARD_W = 16
) (
   input  logic [BOARD_W-1:0] i_above,
   input  logic [BOARD_W-1:0] i_cur,
   input  logic [BOARD_W-1:0] i_below,
   output logic [BOARD_W-1:0] o_next
);

   logic [BOARD_W+1:0] w_above_p;
   logic [BOARD_W+1:0] w_cur_p;
   logic [BOARD_W+1:0] w_below_p;
   logic [NBR_W-1:0]   w_n;

   // Pad each row with one guard column per side: bit 0 is left of column 0
   always_comb begin
`ifdef LIFE_TORUS_EN
      w_above_p = {i_above[0], i_above, i_above[BOARD_W-1]};
      w_cur_p   = {i_cur[0],   i_cur,   i_cur[BOARD_W-1]};
      w_below_p = {i_below[0], i_below, i_below[BOARD_W-1]};
`else
      w_above_p = {1'b0, i_above, 1'b0};
      w_cur_p   = {1'b0, i_cur,   1'b0};
      w_below_p = {1'b0, i_below, 1'b0};
`endif
   end

   // Neighbour count and rule per column
   always_comb begin
      o_next = '0;
      w_n    = '0;
      for (int c = 0; c < BOARD_W; c++) begin
         w_n = NBR_W'(w_above_p[c]) + NBR_W'(w_above_p[c+1]) + NBR_W'(w_above_p[c+2])
             + NBR_W'(w_cur_p[c])                            + NBR_W'(w_cur_p[c+2])
             + NBR_W'(w_below_p[c]) + NBR_W'(w_below_p[c+1]) + NBR_W'(w_below_p[c+2]);
         o_next[c] = life_rule(i_cur[c], w_n);
      end
   end

endmodule

// File: rtl/life_gen_engine.sv
// Double-buffered Game-of-Life engine computing one row per clock; rows wrap when LIFE_TORUS_EN
// is defined. The display buffer is read combinationally by the pixel colour logic.
module life_gen_engine
   import life_pkg::*;
#(
   parameter int BOARD_W = 16,
   parameter int BOARD_H = 16,
   parameter int GEN_DIV = 32,
   parameter int GEN_W   = 16,
   parameter logic [BOARD_W*BOARD_H-1:0] INIT_PATTERN = '0
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       i_frame_tick,
   input  logic                       i_run,
   input  logic                       i_step,
   input  logic                       i_seed_load,
   input  logic [$clog2(BOARD_W)-1:0] i_rd_col,
   input  logic [$clog2(BOARD_H)-1:0] i_rd_row,
   output logic                       o_rd_alive,
   output logic                       o_busy,
   output logic                       o_gen_done,
   output logic [GEN_W-1:0]           o_gen_count
);

   localparam int ROW_W = $clog2(BOARD_H);
   localparam int FC_W  = $clog2(GEN_DIV + 1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(BOARD_H - 1);
   localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(GEN_DIV - 1);

   // r_buf[r_sel] is the display buffer, r_buf[~r_sel] the work buffer
   logic [1:0][BOARD_H-1:0][BOARD_W-1:0] r_buf;
   logic                r_sel;
   state_t              r_state;
   state_t              w_state_nxt;
   logic [ROW_W-1:0]    r_row;
   logic [ROW_W-1:0]    w_row_up;
   logic [ROW_W-1:0]    w_row_dn;
   logic [FC_W-1:0]     r_frame_cnt;
   logic                r_pending;
   logic                r_busy;
   logic                r_gen_done;
   logic [GEN_W-1:0]    r_gen_count;
   logic                w_frame_start;
   logic                w_start;
   logic [BOARD_W-1:0]  w_above;
   logic [BOARD_W-1:0]  w_cur;
   logic [BOARD_W-1:0]  w_below;
   logic [BOARD_W-1:0]  w_next_row;

   assign w_frame_start = i_run & i_frame_tick & (r_frame_cnt == FC_LAST);
   assign w_start       = (w_frame_start | (i_step & ~i_run)) & ~i_seed_load;

   // Frame tick divider, held clear whenever free-run is off
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_frame_cnt <= '0;
      end else if (i_seed_load || !i_run) begin
         r_frame_cnt <= '0;
      end else if (i_frame_tick) begin
         r_frame_cnt <= (r_frame_cnt == FC_LAST) ? '0 : r_frame_cnt + FC_W'(1);
      end else begin
         r_frame_cnt <= r_frame_cnt;
      end
   end

   // Display rows around the current row; rows beyond the board edge wrap or read as dead
   always_comb begin
      w_row_up = (r_row == '0) ? LAST_ROW : r_row - ROW_W'(1);
      w_row_dn = (r_row == LAST_ROW) ? '0 : r_row + ROW_W'(1);
      w_cur    = r_buf[r_sel][r_row];
`ifdef LIFE_TORUS_EN
      w_above  = r_buf[r_sel][w_row_up];
      w_below  = r_buf[r_sel][w_row_dn];
`else
      if (r_row == '0) begin
         w_above = '0;
      end else begin
         w_above = r_buf[r_sel][w_row_up];
      end
      if (r_row == LAST_ROW) begin
         w_below = '0;
      end else begin
         w_below = r_buf[r_sel][w_row_dn];
      end
`endif
   end

   life_row_update #(.BOARD_W(BOARD_W)) u_row_update (
      .i_above (w_above),
      .i_cur   (w_cur),
      .i_below (w_below),
      .o_next  (w_next_row)
   );

   // Generation sequencer state register
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state: seed_load aborts any generation in flight
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (!i_seed_load && (w_start || r_pending)) begin
               w_state_nxt = COMPUTE;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         COMPUTE: begin
            if (i_seed_load) begin
               w_state_nxt = IDLE;
            end else if (r_row == LAST_ROW) begin
               w_state_nxt = SWAP;
            end else begin
               w_state_nxt = COMPUTE;
            end
         end
         SWAP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Buffers, row counter, pending request and registered status outputs
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_buf       <= {{(BOARD_W*BOARD_H){1'b0}}, INIT_PATTERN};
         r_sel       <= 1'b0;
         r_row       <= '0;
         r_pending   <= 1'b0;
         r_busy      <= 1'b0;
         r_gen_done  <= 1'b0;
         r_gen_count <= '0;
      end else begin
         r_busy     <= (w_state_nxt != IDLE);
         r_gen_done <= (w_state_nxt == SWAP);
         r_row      <= ((r_state == COMPUTE) && (w_state_nxt == COMPUTE)) ? r_row + ROW_W'(1) : '0;
         if (r_state == COMPUTE) begin
            r_buf[~r_sel][r_row] <= w_next_row;
         end
         if (i_seed_load) begin
            r_buf[r_sel] <= INIT_PATTERN;
            r_gen_count  <= '0;
            r_pending    <= 1'b0;
         end else begin
            if (w_state_nxt == SWAP) begin
               r_sel       <= ~r_sel;
               r_gen_count <= r_gen_count + GEN_W'(1);
            end
            // A request arriving as a pending one is consumed stays queued
            if (r_state == IDLE) begin
               r_pending <= r_pending & w_start;
            end else if (w_start) begin
               r_pending <= 1'b1;
            end
         end
      end
   end

   // Display read port, dead outside the board
   always_comb begin
      o_rd_alive = 1'b0;
      if ((int'(i_rd_col) < BOARD_W) && (int'(i_rd_row) < BOARD_H)) begin
         o_rd_alive = r_buf[r_sel][i_rd_row][i_rd_col];
      end else begin
         o_rd_alive = 1'b0;
      end
   end

   assign o_busy      = r_busy;
   assign o_gen_done  = r_gen_done;
   assign o_gen_count = r_gen_count;

endmodule

// File: tb/tb_life_gen_engine.sv
// Self-checking bench for life_gen_engine: directed scenarios plus randomized traffic
// checked every cycle against a board-level reference model.
module tb_life_gen_engine;

   localparam int BW = 10;
   localparam int BH = 10;
   localparam int GD = 4;
   localparam int GW = 4;
   localparam int CW = $clog2(BW);
   localparam int RW = $clog2(BH);
   // block at (0,0)..(1,1), horizontal blinker at row 5, cols 4..6
   localparam logic [BW*BH-1:0] INIT_P = (100'd1 << 0) | (100'd1 << 1) | (100'd1 << 10) | (100'd1 << 11)
                                       | (100'd1 << 54) | (100'd1 << 55) | (100'd1 << 56);

   logic clk = 1'b0;
   logic reset, ft, run, step, seed;
   logic [CW-1:0] rd_col;
   logic [RW-1:0] rd_row;
   logic rd_alive, busy, gen_done;
   logic [GW-1:0] gen_count;

   life_gen_engine #(.BOARD_W(BW), .BOARD_H(BH), .GEN_DIV(GD), .GEN_W(GW), .INIT_PATTERN(INIT_P)) dut (
      .i_clk(clk), .i_reset(reset), .i_frame_tick(ft), .i_run(run), .i_step(step),
      .i_seed_load(seed), .i_rd_col(rd_col), .i_rd_row(rd_row), .o_rd_alive(rd_alive),
      .o_busy(busy), .o_gen_done(gen_done), .o_gen_count(gen_count)
   );

   always #10 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int done_pulses = 0;
   int done_cyc_q[$];
   logic [BW*BH-1:0] init_v = INIT_P;

   // reference model: board, generation count, divider, completion cycle of current generation
   bit md[BH][BW];
   int m_cnt, m_fc, m_done;
   bit m_pend;

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_load();
      for (int r = 0; r < BH; r++)
         for (int c = 0; c < BW; c++)
            md[r][c] = init_v[r*BW + c];
   endtask

   task automatic model_gen();
      bit nx[BH][BW];
      int n, rr, cc;
      for (int r = 0; r < BH; r++) begin
         for (int c = 0; c < BW; c++) begin
            n = 0;
            for (int dr = -1; dr <= 1; dr++) begin
               for (int dc = -1; dc <= 1; dc++) begin
                  if (dr != 0 || dc != 0) begin
                     rr = r + dr;
                     cc = c + dc;
`ifdef LIFE_TORUS_EN
                     rr = (rr + BH) % BH;
                     cc = (cc + BW) % BW;
                     n += int'(md[rr][cc]);
`else
                     if (rr >= 0 && rr < BH && cc >= 0 && cc < BW) n += int'(md[rr][cc]);
`endif
                  end
               end
            end
            nx[r][c] = (n == 3) || (md[r][c] && n == 2);
         end
      end
      md = nx;
   endtask

   function automatic bit exp_cell(input int r, input int c);
      if (r < BH && c < BW) return md[r][c];
      return 1'b0;
   endfunction

   task automatic model_reset();
      model_load();
      m_cnt = 0; m_fc = 0; m_pend = 0; m_done = -1; cyc = 0;
   endtask

   // predicts the next cycle from the inputs the DUT will sample at the coming edge
   task automatic model_advance();
      bit fire, req, idle;
      fire = 0;
      if (run) begin
         if (ft) begin
            if (m_fc == GD - 1) begin m_fc = 0; fire = 1; end
            else m_fc++;
         end
      end else m_fc = 0;
      req = fire || (step && !run);
      if (seed) begin
         model_load();
         m_cnt = 0; m_pend = 0; m_fc = 0;
         if (m_done > cyc) m_done = cyc;
      end else begin
         idle = (cyc > m_done);
         if (idle) begin
            if (req || m_pend) begin
               m_done = cyc + BH + 1;
               m_pend = m_pend && req;
            end
         end else if (req) m_pend = 1;
         if (cyc + 1 == m_done) begin
            model_gen();
            m_cnt = (m_cnt + 1) % (1 << GW);
         end
      end
   endtask

   // per-cycle compare against the model
   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            model_reset();
            chk("rst_busy", busy, 0);
            chk("rst_gen_done", gen_done, 0);
            chk("rst_gen_count", gen_count, 0);
            chk("rst_rd_alive", rd_alive, exp_cell(int'(rd_row), int'(rd_col)));
         end else begin
            chk("busy", busy, (cyc <= m_done));
            chk("gen_done", gen_done, (cyc == m_done));
            chk("gen_count", gen_count, m_cnt);
            chk("rd_alive", rd_alive, exp_cell(int'(rd_row), int'(rd_col)));
            if (gen_done) begin
               done_pulses++;
               done_cyc_q.push_back(cyc);
            end
            model_advance();
            cyc++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      step = 1'b0; seed = 1'b0; ft = 1'b0;
      rd_col = CW'($urandom_range(0, (1 << CW) - 1));
      rd_row = RW'($urandom_range(0, (1 << RW) - 1));
   endtask

   task automatic peek(input string nm, input int r, input int c, input int exp);
      rd_row = RW'(r);
      rd_col = CW'(c);
      #1;
      chk(nm, rd_alive, exp);
   endtask

   task automatic wait_done(input string nm);
      int k = 0;
      while (!gen_done && k < 100) begin tick(); k++; end
      if (!gen_done) chk({nm, "_timeout"}, 0, 1);
   endtask

   task automatic wait_idle(input string nm);
      int k = 0;
      while (busy && k < 100) begin tick(); k++; end
      if (busy) chk({nm, "_timeout"}, 1, 0);
   endtask

   int base, qsz;

   initial begin
      reset = 1'b1; ft = 1'b0; run = 1'b0; step = 1'b0; seed = 1'b0; rd_col = '0; rd_row = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // reset contents and out-of-range read
      chk("reset_busy", busy, 0);
      peek("init_5_4", 5, 4, 1);
      peek("init_4_5", 4, 5, 0);
      peek("init_0_0", 0, 0, 1);
      peek("oob_row", 12, 3, 0);
      tick();

      // blinker: latency of one step, then back to the original phase
      step = 1'b1;
      chk("pre_busy", busy, 0);
      tick();
      chk("lat_busy", busy, 1);
      repeat (BH - 1) tick();
      chk("lat_no_done", gen_done, 0);
      tick();
      chk("lat_done", gen_done, 1);
      peek("blink_4_5", 4, 5, 1);
      peek("blink_6_5", 6, 5, 1);
      peek("blink_5_4", 5, 4, 0);
      peek("blink_5_6", 5, 6, 0);
      chk("blink_cnt", gen_count, 1);
      wait_idle("blink1");
      step = 1'b1; tick();
      wait_done("blink2");
      peek("blink2_5_4", 5, 4, 1);
      peek("blink2_4_5", 4, 5, 0);
      wait_idle("blink2");

      // block still life over 10 steps
      seed = 1'b1; tick();
      base = done_pulses;
      for (int i = 0; i < 10; i++) begin
         step = 1'b1; tick();
         wait_done("block");
         wait_idle("block");
      end
      chk("block_cnt", gen_count, 10);
      chk("block_pulses", done_pulses - base, 10);
      peek("block_0_0", 0, 0, 1);
      peek("block_1_1", 1, 1, 1);
      peek("block_2_2", 2, 2, 0);
      peek("block_5_5", 5, 5, 1);

      // frame divider: 8 ticks -> 2 gens; run drop mid-count clears the divider
      seed = 1'b1; tick();
      base = done_pulses;
      run = 1'b1;
      for (int i = 0; i < 8; i++) begin ft = 1'b1; repeat (30) tick(); end
      chk("div_pulses", done_pulses - base, 2);
      chk("div_cnt", gen_count, 2);
      for (int i = 0; i < 3; i++) begin ft = 1'b1; repeat (30) tick(); end
      run = 1'b0; tick();
      run = 1'b1;
      ft = 1'b1; repeat (30) tick();
      chk("div_cleared", done_pulses - base, 2);
      for (int i = 0; i < 3; i++) begin ft = 1'b1; repeat (30) tick(); end
      chk("div_resume", done_pulses - base, 3);
      run = 1'b0; tick();

      // pending: one queued request, third request dropped
      wait_idle("pend");
      base = done_pulses;
      qsz = done_cyc_q.size();
      step = 1'b1; tick();
      step = 1'b1; tick();
      step = 1'b1; tick();
      repeat (3 * (BH + 2) + 5) tick();
      chk("pend_pulses", done_pulses - base, 2);
      if (done_cyc_q.size() >= qsz + 2) chk("pend_gap", done_cyc_q[qsz+1] - done_cyc_q[qsz], BH + 2);
      else chk("pend_gap_missing", done_cyc_q.size() - qsz, 2);

      // seed_load at COMPUTE row 3 aborts without a visible generation
      seed = 1'b1; tick();
      step = 1'b1; tick();
      wait_done("abort_pre");
      wait_idle("abort_pre");
      step = 1'b1;
      repeat (4) tick();
      seed = 1'b1;
      base = done_pulses;
      tick();
      repeat (BH + 5) tick();
      chk("abort_pulses", done_pulses - base, 0);
      chk("abort_cnt", gen_count, 0);
      chk("abort_busy", busy, 0);
      peek("abort_5_4", 5, 4, 1);
      peek("abort_4_5", 4, 5, 0);
      tick();

      // asynchronous reset mid-generation
      step = 1'b1; tick();
      wait_done("areset_pre");
      wait_idle("areset_pre");
      step = 1'b1;
      repeat (3) tick();
      #3 reset = 1'b1;
      #1;
      chk("areset_busy", busy, 0);
      chk("areset_done", gen_done, 0);
      chk("areset_cnt", gen_count, 0);
      peek("areset_5_4", 5, 4, 1);
      peek("areset_4_5", 4, 5, 0);
      tick();
      reset = 1'b0;

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) < 3) run = ~run;
         ft   = ($urandom_range(0, 7) == 0);
         step = ($urandom_range(0, 15) == 0);
         seed = ($urandom_range(0, 299) == 0);
         tick();
      end
      run = 1'b0;
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
